// File: rtl/line_memory_pkg.sv
// line_memory shared types and constants.
// The cache imports line_t and ByteOffsetBits from here.
package line_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lm_state_e;

  localparam int unsigned ByteOffsetBits  = 4;
  localparam int unsigned WordOffsetBits  = 2;
  localparam int unsigned DefWordsPerLine = 4;

  typedef logic [DefWordsPerLine-1:0][31:0] line_t;

  // Power-up word contents: each word holds its own byte address.
  function automatic logic [31:0] addr_pattern(
    input logic [31:0] word_idx
  );
    return word_idx << WordOffsetBits;
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// Line-fill request/response bundle between cache and line_memory.
// master = requester (cache), slave = line_memory.
interface line_memory_if
  import line_memory_pkg::*;
#(
  parameter int unsigned NrWordsPerLine = DefWordsPerLine
) ();

  logic                        req_en_i;
  logic [31:0]                 req_addr_i;
  logic                        resp_valid_o;
  logic [32*NrWordsPerLine-1:0] resp_data_o;
  logic                        busy_o;

  modport master (
    output req_en_i,
    output req_addr_i,
    input  resp_valid_o,
    input  resp_data_o,
    input  busy_o
  );

  modport slave (
    input  req_en_i,
    input  req_addr_i,
    output resp_valid_o,
    output resp_data_o,
    output busy_o
  );

endinterface

// File: rtl/line_memory_array.sv
// line_memory storage and line read mux.
// MEM_PRELOAD_EN adds a word-wide preload write port.
module line_memory_array
  import line_memory_pkg::*;
#(
  parameter int unsigned NrWordsPerLine = 4,
  parameter int unsigned MemWords       = 4096,
  localparam int unsigned WselW = $clog2(NrWordsPerLine),
  localparam int unsigned MemAw = $clog2(MemWords),
  localparam int unsigned IdxW  = MemAw - WselW
) (
`ifdef MEM_PRELOAD_EN
  input  logic                           clk_i,
  input  logic                           pl_we_i,
  input  logic [31:0]                    pl_addr_i,
  input  logic [31:0]                    pl_wdata_i,
`endif
  input  logic [IdxW-1:0]                rd_idx_i,
  output logic [NrWordsPerLine-1:0][31:0] rd_line_o
);

`ifdef MEM_PRELOAD_EN
  // Store the XOR against the address pattern so a zero
  // power-up image already reads back as the pattern.
  logic [31:0] mem_q [MemWords] = '{default: '0};
  logic [MemAw-1:0] wr_a;
  logic unused_pl;

  assign wr_a = pl_addr_i[MemAw+1:WordOffsetBits];
  assign unused_pl = ^{pl_addr_i[31:MemAw+2],
                       pl_addr_i[WordOffsetBits-1:0]};

  always_ff @(posedge clk_i) begin
    if (pl_we_i) begin
      mem_q[wr_a] <= pl_wdata_i ^ addr_pattern(32'(wr_a));
    end
  end

  always_comb begin
    logic [MemAw-1:0] a;
    for (int w = 0; w < NrWordsPerLine; w++) begin
      a = {rd_idx_i, WselW'(w)};
      rd_line_o[w] = mem_q[a] ^ addr_pattern(32'(a));
    end
  end
`else
  always_comb begin
    logic [MemAw-1:0] a;
    for (int w = 0; w < NrWordsPerLine; w++) begin
      a = {rd_idx_i, WselW'(w)};
      rd_line_o[w] = addr_pattern(32'(a));
    end
  end
`endif

endmodule

// File: rtl/line_memory.sv
// Backing-store responder for cache line fills.
// Optional MEM_PRELOAD_EN exposes the pl_* preload port.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int unsigned NrWordsPerLine = 4,
  parameter int unsigned MemWords       = 4096,
  parameter int unsigned Latency        = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
`ifdef MEM_PRELOAD_EN
  input  logic        pl_we_i,
  input  logic [31:0] pl_addr_i,
  input  logic [31:0] pl_wdata_i,
`endif
  line_memory_if.slave bus
);

  localparam int unsigned WselW   = $clog2(NrWordsPerLine);
  localparam int unsigned MemAw   = $clog2(MemWords);
  localparam int unsigned LineOff = WordOffsetBits + WselW;
  localparam int unsigned IdxW    = MemAw - WselW;

  typedef logic [NrWordsPerLine-1:0][31:0] lline_t;

  lm_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic valid_q, valid_d;
  lline_t data_q, data_d;

  logic [IdxW-1:0] req_idx;
  lline_t rd_line;
  logic unused_addr;

  assign req_idx = bus.req_addr_i[MemAw+1:LineOff];
  assign unused_addr = ^{bus.req_addr_i[31:MemAw+2],
                         bus.req_addr_i[LineOff-1:0]};

  line_memory_array #(
    .NrWordsPerLine(NrWordsPerLine),
    .MemWords      (MemWords)
  ) u_array (
`ifdef MEM_PRELOAD_EN
    .clk_i     (clk_i),
    .pl_we_i   (pl_we_i),
    .pl_addr_i (pl_addr_i),
    .pl_wdata_i(pl_wdata_i),
`endif
    .rd_idx_i  (idx_q),
    .rd_line_o (rd_line)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    data_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_en_i) begin
          idx_d   = req_idx;
          cnt_d   = 8'(Latency - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.req_en_i) begin
          state_d = IDLE;
        end else if (req_idx != idx_q) begin
          idx_d = req_idx;
          cnt_d = 8'(Latency - 1);
        end else if (cnt_q == 8'd0) begin
          valid_d = 1'b1;
          data_d  = rd_line;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // Requester still holds req_en here; never re-accept it.
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.resp_valid_o = valid_q;
  assign bus.resp_data_o  = data_q;
  assign bus.busy_o       = (state_q != IDLE);

endmodule
